// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle sequencer: state encodings,
// latched instruction class, and the no-branch opcode.
package mc_pkg;

   typedef enum logic [2:0] {
      ST_RST  = 3'd0,
      ST_IF   = 3'd1,
      ST_ID   = 3'd2,
      ST_EX   = 3'd3,
      ST_MEM  = 3'd4,
      ST_WB   = 3'd5,
      ST_IDLE = 3'd6
   } state_t;

   typedef struct packed {
      logic ld;
      logic st;
      logic wr;
      logic br;
   } cls_t;

   localparam logic [3:0] BR_NONE = 4'd0;

   // A load+store combination is illegal; it is folded into a load.
   function automatic cls_t decode_cls(
      input logic       ld,
      input logic       st,
      input logic       wr,
      input logic [3:0] brop
   );
      cls_t c;
      c.ld = ld;
      c.st = st & ~ld;
      c.wr = wr;
      c.br = (brop != BR_NONE);
      return c;
   endfunction

endpackage

// File: rtl/multicycle_sequencer_perf_counters.sv
// Cycle and retired-instruction counters, both wrapping.
// Ports: clk, rst_n, i_incCycle, i_incInst, o_cycleCnt, o_instCnt.
module perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_incCycle,
   input  logic             i_incInst,
   output logic [CNT_W-1:0] o_cycleCnt,
   output logic [CNT_W-1:0] o_instCnt
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_cycle;
   logic [CNT_W-1:0] r_inst;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle <= '0;
         r_inst  <= '0;
      end else begin
         if (i_incCycle) r_cycle <= r_cycle + ONE;
         if (i_incInst)  r_inst  <= r_inst + ONE;
      end
   end

   assign o_cycleCnt = r_cycle;
   assign o_instCnt  = r_inst;

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS stage sequencer: per-cycle strobes from decoded class.
// Ports: clk/rst_n, decoder class in, mem ready in, strobes/stage/counters out.
module multicycle_sequencer
   import mc_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_sLoad,
   input  logic             i_dMemWe,
   input  logic             i_regWe,
   input  logic [3:0]       i_brOP,
   input  logic             i_brTaken,
   input  logic             i_halt,
   input  logic             i_iMemReady,
   input  logic             i_dMemReady,
   output logic             o_iMemReq,
   output logic             o_irWe,
   output logic             o_pcWe,
   output logic             o_pcSrcBr,
   output logic             o_dMemReq,
   output logic             o_dMemWe,
   output logic             o_regWe,
   output logic [2:0]       o_stage,
   output logic             o_halted,
   output logic [CNT_W-1:0] o_cycleCnt,
   output logic [CNT_W-1:0] o_instCnt
);

   state_t r_state;
   state_t w_next;
   cls_t   r_cls;
   logic   w_retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_RST;
      else        r_state <= w_next;
   end

   // Class is captured once in ID; decoder inputs are don't-care afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cls <= '0;
      end else if (r_state == ST_ID) begin
         r_cls <= decode_cls(i_sLoad, i_dMemWe, i_regWe, i_brOP);
      end
   end

   always_comb begin
      w_next    = r_state;
      w_retire  = 1'b0;
      o_iMemReq = 1'b0;
      o_irWe    = 1'b0;
      o_pcWe    = 1'b0;
      o_pcSrcBr = 1'b0;
      o_dMemReq = 1'b0;
      o_dMemWe  = 1'b0;
      o_regWe   = 1'b0;
      unique case (r_state)
         ST_RST: w_next = ST_IF;
         ST_IF: begin
            o_iMemReq = 1'b1;
            if (i_iMemReady) begin
               o_irWe = 1'b1;
               o_pcWe = 1'b1;
               w_next = ST_ID;
            end
         end
         ST_ID: w_next = ST_EX;
         ST_EX: begin
            if (r_cls.br && i_brTaken) begin
               o_pcWe    = 1'b1;
               o_pcSrcBr = 1'b1;
            end
            if (r_cls.ld || r_cls.st) w_next   = ST_MEM;
            else if (r_cls.wr)        w_next   = ST_WB;
            else                      w_retire = 1'b1;
         end
         ST_MEM: begin
            o_dMemReq = 1'b1;
            o_dMemWe  = r_cls.st;
            if (i_dMemReady) begin
               if (r_cls.ld) w_next   = ST_WB;
               else          w_retire = 1'b1;
            end
         end
         ST_WB: begin
            o_regWe  = 1'b1;
            w_retire = 1'b1;
         end
         ST_IDLE: if (!i_halt) w_next = ST_IF;
         default: w_next = ST_RST;
      endcase
      // Halt only takes effect at an instruction boundary.
      if (w_retire) w_next = i_halt ? ST_IDLE : ST_IF;
   end

   assign o_stage  = r_state;
   assign o_halted = (r_state == ST_IDLE);

   perf_counters #(
      .CNT_W(CNT_W)
   ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_incCycle(1'b1),
      .i_incInst (w_retire),
      .o_cycleCnt(o_cycleCnt),
      .o_instCnt (o_instCnt)
   );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer against a per-instruction
// cycle-sequence model built from the instruction class and wait counts.
module tb_multicycle_sequencer;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_sLoad, i_dMemWe, i_regWe;
   logic [3:0]    i_brOP;
   logic          i_brTaken, i_halt, i_iMemReady, i_dMemReady;
   logic          o_iMemReq, o_irWe, o_pcWe, o_pcSrcBr;
   logic          o_dMemReq, o_dMemWe, o_regWe;
   logic [2:0]    o_stage;
   logic          o_halted;
   logic [CW-1:0] o_cycleCnt, o_instCnt;
   logic [6:0]    w_stb;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [CW-1:0] exp_cyc;
   logic [CW-1:0] exp_inst;

   typedef struct {
      logic [2:0] stg;
      logic [6:0] stb;
      bit         ret;
      bit         irdy;
      bit         drdy;
   } cyc_t;

   multicycle_sequencer #(.CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_sLoad    (i_sLoad),
      .i_dMemWe   (i_dMemWe),
      .i_regWe    (i_regWe),
      .i_brOP     (i_brOP),
      .i_brTaken  (i_brTaken),
      .i_halt     (i_halt),
      .i_iMemReady(i_iMemReady),
      .i_dMemReady(i_dMemReady),
      .o_iMemReq  (o_iMemReq),
      .o_irWe     (o_irWe),
      .o_pcWe     (o_pcWe),
      .o_pcSrcBr  (o_pcSrcBr),
      .o_dMemReq  (o_dMemReq),
      .o_dMemWe   (o_dMemWe),
      .o_regWe    (o_regWe),
      .o_stage    (o_stage),
      .o_halted   (o_halted),
      .o_cycleCnt (o_cycleCnt),
      .o_instCnt  (o_instCnt)
   );

   assign w_stb = {o_iMemReq, o_irWe, o_pcWe, o_pcSrcBr,
                   o_dMemReq, o_dMemWe, o_regWe};

   always #5 clk = ~clk;

   // Runs one instruction from IF; starts and ends 1 time unit after a posedge.
   task automatic run_instr(input bit ld, input bit st, input bit wr,
                            input logic [3:0] brop, input bit taken,
                            input int iw, input int dw, input bit halt);
      cyc_t q[$];
      cyc_t c;
      bit   ste, mem, wb, br;
      ste = st && !ld;
      mem = ld || ste;
      br  = (brop != 4'd0);
      wb  = ld || (wr && !mem);
      for (int k = 0; k <= iw; k++) begin
         c.stg = 3'd1; c.ret = 0; c.drdy = 0; c.irdy = (k == iw);
         c.stb = (k == iw) ? 7'b1110000 : 7'b1000000;
         q.push_back(c);
      end
      c.stg = 3'd2; c.stb = 7'b0; c.ret = 0; c.irdy = 0; c.drdy = 0;
      q.push_back(c);
      c.stg = 3'd3; c.stb = (br && taken) ? 7'b0011000 : 7'b0;
      c.ret = !mem && !wb;
      q.push_back(c);
      if (mem) begin
         for (int k = 0; k <= dw; k++) begin
            c.stg = 3'd4; c.stb = {4'b0, 1'b1, ste, 1'b0};
            c.drdy = (k == dw); c.ret = (k == dw) && !ld;
            q.push_back(c);
         end
      end
      if (wb) begin
         c.stg = 3'd5; c.stb = 7'b0000001; c.ret = 1; c.drdy = 0;
         q.push_back(c);
      end
      foreach (q[j]) begin
         if (q[j].stg <= 3'd2) begin
            i_sLoad = ld; i_dMemWe = st; i_regWe = wr; i_brOP = brop;
         end else begin
            i_sLoad = 1'($urandom); i_dMemWe = 1'($urandom);
            i_regWe = 1'($urandom); i_brOP = 4'($urandom);
         end
         i_iMemReady = (q[j].stg == 3'd1) ? q[j].irdy : 1'($urandom);
         i_dMemReady = (q[j].stg == 3'd4) ? q[j].drdy : 1'($urandom);
         i_brTaken   = (q[j].stg == 3'd3) ? taken : 1'($urandom);
         i_halt      = q[j].ret ? halt : 1'($urandom);
         @(negedge clk);
         n_cmp++;
         if (o_stage !== q[j].stg) begin
            n_bad++;
            $display("FAIL stage cyc%0d: got %0d want %0d", j, o_stage, q[j].stg);
         end
         n_cmp++;
         if ({w_stb, o_halted} !== {q[j].stb, 1'b0}) begin
            n_bad++;
            $display("FAIL strobes st%0d: got %b/%b want %b/0",
                     q[j].stg, w_stb, o_halted, q[j].stb);
         end
         n_cmp++;
         if ({o_cycleCnt, o_instCnt} !== {exp_cyc, exp_inst}) begin
            n_bad++;
            $display("FAIL counters: got %0d/%0d want %0d/%0d",
                     o_cycleCnt, o_instCnt, exp_cyc, exp_inst);
         end
         @(posedge clk);
         exp_cyc++;
         if (q[j].ret) exp_inst++;
         #1;
      end
   endtask

   task automatic random_instr(input bit halt);
      logic [3:0] b;
      b = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      run_instr(1'($urandom), 1'($urandom), 1'($urandom), b, 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), halt);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      i_sLoad = 0; i_dMemWe = 0; i_regWe = 0; i_brOP = 0; i_brTaken = 1;
      i_halt = 0; i_iMemReady = 1; i_dMemReady = 1;
      #12;
      n_cmp++;
      if ({o_stage, w_stb, o_halted, o_cycleCnt, o_instCnt} !== '0) begin
         n_bad++;
         $display("FAIL reset_hold: stage %0d stb %b halted %b cnt %0d/%0d want all 0",
                  o_stage, w_stb, o_halted, o_cycleCnt, o_instCnt);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_cyc = '0; exp_inst = '0;
      @(negedge clk);
      n_cmp++;
      if ({o_stage, w_stb, o_cycleCnt} !== '0) begin
         n_bad++;
         $display("FAIL reset_release: stage %0d stb %b cyc %0d want 0",
                  o_stage, w_stb, o_cycleCnt);
      end
      @(posedge clk);
      exp_cyc++;
      #1;
   endtask

   task automatic test_classes();
      run_instr(0, 0, 1, 4'd0, 0, 0, 0, 0);
      run_instr(1, 0, 1, 4'd0, 0, 0, 2, 0);
      run_instr(0, 1, 0, 4'd0, 0, 0, 0, 0);
      run_instr(0, 0, 0, 4'd1, 1, 0, 0, 0);
      run_instr(0, 0, 1, 4'd5, 1, 0, 0, 0);
      run_instr(1, 1, 0, 4'd0, 0, 1, 1, 0);
      run_instr(0, 0, 0, 4'd2, 0, 2, 0, 0);
   endtask

   task automatic test_halt();
      run_instr(0, 0, 1, 4'd0, 0, 0, 0, 1);
      for (int k = 0; k < 4; k++) begin
         i_halt = (k < 3);
         i_iMemReady = 1'($urandom); i_dMemReady = 1'($urandom);
         i_brTaken = 1'($urandom); i_sLoad = 1'($urandom);
         @(negedge clk);
         n_cmp++;
         if ({o_stage, w_stb, o_halted} !== {3'd6, 7'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL idle%0d: stage %0d stb %b halted %b want 6/0/1",
                     k, o_stage, w_stb, o_halted);
         end
         n_cmp++;
         if ({o_cycleCnt, o_instCnt} !== {exp_cyc, exp_inst}) begin
            n_bad++;
            $display("FAIL idle_cnt%0d: got %0d/%0d want %0d/%0d",
                     k, o_cycleCnt, o_instCnt, exp_cyc, exp_inst);
         end
         @(posedge clk);
         exp_cyc++;
         #1;
      end
      run_instr(0, 1, 0, 4'd0, 0, 1, 0, 0);
   endtask

   task automatic test_reset_mid();
      i_sLoad = 1; i_dMemWe = 0; i_regWe = 1; i_brOP = 0;
      i_iMemReady = 1; i_dMemReady = 0; i_halt = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({o_stage, o_dMemReq} !== {3'd4, 1'b1}) begin
         n_bad++;
         $display("FAIL mid_mem: stage %0d dreq %b want 4/1", o_stage, o_dMemReq);
      end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({o_stage, w_stb, o_halted, o_cycleCnt, o_instCnt} !== '0) begin
         n_bad++;
         $display("FAIL mid_reset: stage %0d stb %b cnt %0d/%0d want all 0",
                  o_stage, w_stb, o_cycleCnt, o_instCnt);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_cyc = '0; exp_inst = '0;
      @(negedge clk);
      n_cmp++;
      if ({o_stage, o_cycleCnt} !== '0) begin
         n_bad++;
         $display("FAIL mid_release: stage %0d cyc %0d want 0/0", o_stage, o_cycleCnt);
      end
      @(posedge clk);
      exp_cyc++;
      #1;
      run_instr(0, 0, 1, 4'd0, 0, 0, 0, 0);
   endtask

   task automatic test_wrap();
      while (exp_inst != {CW{1'b1}}) random_instr(0);
      n_cmp++;
      if (o_instCnt !== {CW{1'b1}}) begin
         n_bad++;
         $display("FAIL wrap_pre: got %0d want %0d", o_instCnt, {CW{1'b1}});
      end
      run_instr(0, 0, 0, 4'd3, 1, 0, 0, 0);
      n_cmp++;
      if (o_instCnt !== exp_inst || exp_inst != '0) begin
         n_bad++;
         $display("FAIL wrap: got %0d want 0", o_instCnt);
      end
   endtask

   initial begin
      test_reset();
      test_classes();
      test_halt();
      for (int n = 0; n < 40; n++) random_instr(0);
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
